// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: default field widths and the
// legal range of output register stages. The optional prefix feature is
// enabled by defining IMM_GEN_PREFIX_EN.
package imm_pkg;

    // Default widths
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned IMM_A_W_DEF = 5;
    localparam int unsigned IMM_B_W_DEF = 8;
    localparam int unsigned PFX_W_DEF   = 11;

    // Output register stages and their legal range
    localparam int unsigned PIPE_DEF = 1;
    localparam int unsigned PIPE_MIN = 1;
    localparam int unsigned PIPE_MAX = 2;

endpackage

// File: rtl/imm_ext.sv
// Combinational immediate builder: picks the short or long field, then either
// sign/zero-extends it or appends it below a latched prefix payload.
module imm_ext
    import imm_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned IMM_A_W = IMM_A_W_DEF,
    parameter int unsigned IMM_B_W = IMM_B_W_DEF,
    parameter int unsigned PFX_W   = PFX_W_DEF
) (
    input  logic [IMM_A_W-1:0] imm_a,
    input  logic [IMM_B_W-1:0] imm_b,
    input  logic               sel_b,
    input  logic               zext,
    input  logic               use_pfx,
    input  logic [PFX_W-1:0]   pfx_val,
    output logic [DATA_W-1:0]  ext_c
);

    // Wide enough to hold prefix << longest field plus a full output word,
    // so every variant is formed without intermediate truncation.
    localparam int unsigned WIDE_W = PFX_W + IMM_B_W + DATA_W;

    logic [WIDE_W-1:0] field_z_c;
    logic [WIDE_W-1:0] field_s_c;
    logic [WIDE_W-1:0] pfx_shift_c;
    logic [WIDE_W-1:0] wide_c;

    // Field select, extension and prefix concatenation
    always_comb begin
        field_z_c   = '0;
        field_s_c   = '0;
        pfx_shift_c = '0;
        wide_c      = '0;
        if (sel_b) begin
            field_z_c   = WIDE_W'(imm_b);
            field_s_c   = WIDE_W'($signed(imm_b));
            pfx_shift_c = WIDE_W'(pfx_val) << IMM_B_W;
        end else begin
            field_z_c   = WIDE_W'(imm_a);
            field_s_c   = WIDE_W'($signed(imm_a));
            pfx_shift_c = WIDE_W'(pfx_val) << IMM_A_W;
        end
        // A prefixed immediate always takes the field unsigned; zext is moot
        if (use_pfx) begin
            wide_c = pfx_shift_c | field_z_c;
        end else if (zext) begin
            wide_c = field_z_c;
        end else begin
            wide_c = field_s_c;
        end
    end

    assign ext_c = DATA_W'(wide_c);

endmodule

// File: rtl/imm_gen.sv
// Immediate generator: decode-slot immediate extension with an optional
// prefix register (enabled by defining IMM_GEN_PREFIX_EN) and PIPE output
// register stages (1 or 2). Synchronous active-high reset.
module imm_gen
    import imm_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned IMM_A_W = IMM_A_W_DEF,
    parameter int unsigned IMM_B_W = IMM_B_W_DEF,
    parameter int unsigned PFX_W   = PFX_W_DEF,
    parameter int unsigned PIPE    = PIPE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [IMM_A_W-1:0] imm_a,
    input  logic [IMM_B_W-1:0] imm_b,
    input  logic               sel_b,
    input  logic               zext,
    input  logic               pfx_load,
    input  logic [PFX_W-1:0]   pfx_data,
    input  logic               stall,
    input  logic               flush,
    input  logic               err_clr,
    output logic [DATA_W-1:0]  out,
    output logic               out_valid,
    output logic               pfx_pending,
    output logic               pfx_orphan
);

    logic              accept_c;
    logic              use_pfx_c;
    logic [PFX_W-1:0]  pfx_val_c;
    logic [DATA_W-1:0] ext_c;

`ifdef IMM_GEN_PREFIX_EN
    logic [PFX_W-1:0] pfx_reg;

    // A prefix slot never carries an immediate of its own
    assign accept_c  = valid_in & ~pfx_load & ~stall & ~flush;
    assign use_pfx_c = pfx_pending;
    assign pfx_val_c = pfx_reg;

    // Prefix latch, pending flag and sticky orphan flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pfx_reg     <= '0;
            pfx_pending <= 1'b0;
            pfx_orphan  <= 1'b0;
        end else if (flush) begin
            pfx_pending <= 1'b0;
            if (pfx_pending) begin
                pfx_orphan <= 1'b1;
            end else if (err_clr) begin
                pfx_orphan <= 1'b0;
            end
        end else if (!stall) begin
            if (pfx_load) begin
                pfx_reg     <= pfx_data;
                pfx_pending <= 1'b1;
            end else if (valid_in) begin
                pfx_pending <= 1'b0;
            end
            if (err_clr) begin
                pfx_orphan <= 1'b0;
            end
        end
    end
`else
    logic unused_pfx_c;

    assign accept_c     = valid_in & ~stall & ~flush;
    assign use_pfx_c    = 1'b0;
    assign pfx_val_c    = '0;
    assign pfx_pending  = 1'b0;
    assign pfx_orphan   = 1'b0;
    assign unused_pfx_c = ^{pfx_load, pfx_data, err_clr};
`endif

    imm_ext #(
        .DATA_W  (DATA_W),
        .IMM_A_W (IMM_A_W),
        .IMM_B_W (IMM_B_W),
        .PFX_W   (PFX_W)
    ) u_ext (
        .imm_a   (imm_a),
        .imm_b   (imm_b),
        .sel_b   (sel_b),
        .zext    (zext),
        .use_pfx (use_pfx_c),
        .pfx_val (pfx_val_c),
        .ext_c   (ext_c)
    );

    generate
        if (PIPE >= PIPE_MAX) begin : g_pipe2
            logic              s1_valid;
            logic [DATA_W-1:0] s1_data;

            // Two-stage output pipeline; data regs only load with a valid beat
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid  <= 1'b0;
                    s1_data   <= '0;
                    out_valid <= 1'b0;
                    out       <= '0;
                end else if (flush) begin
                    s1_valid  <= 1'b0;
                    out_valid <= 1'b0;
                end else if (!stall) begin
                    s1_valid  <= accept_c;
                    if (accept_c) begin
                        s1_data <= ext_c;
                    end
                    out_valid <= s1_valid;
                    if (s1_valid) begin
                        out <= s1_data;
                    end
                end
            end
        end else begin : g_pipe1
            // Single output stage; out holds its last value between beats
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    out       <= '0;
                end else if (flush) begin
                    out_valid <= 1'b0;
                end else if (!stall) begin
                    out_valid <= accept_c;
                    if (accept_c) begin
                        out <= ext_c;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen.sv
// Bench for imm_gen: PIPE=1 and PIPE=2 instances share one stimulus stream;
// a reference model pushes expected post-edge outputs into a queue that a
// separate monitor pops and compares one cycle at a time.
module tb_imm_gen;

`ifdef IMM_GEN_PREFIX_EN
    localparam bit PFX_EN = 1'b1;
`else
    localparam bit PFX_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [4:0]  imm_a;
    logic [7:0]  imm_b;
    logic        sel_b;
    logic        zext;
    logic        pfx_load;
    logic [10:0] pfx_data;
    logic        stall;
    logic        flush;
    logic        err_clr;

    logic [15:0] o1, o2;
    logic        ov1, ov2, pp1, pp2, po1, po2;

    int checks = 0;
    int errors = 0;

    imm_gen #(.PIPE(1)) u_p1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .imm_a(imm_a), .imm_b(imm_b),
        .sel_b(sel_b), .zext(zext), .pfx_load(pfx_load), .pfx_data(pfx_data),
        .stall(stall), .flush(flush), .err_clr(err_clr), .out(o1),
        .out_valid(ov1), .pfx_pending(pp1), .pfx_orphan(po1)
    );

    imm_gen #(.PIPE(2)) u_p2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .imm_a(imm_a), .imm_b(imm_b),
        .sel_b(sel_b), .zext(zext), .pfx_load(pfx_load), .pfx_data(pfx_data),
        .stall(stall), .flush(flush), .err_clr(err_clr), .out(o2),
        .out_valid(ov2), .pfx_pending(pp2), .pfx_orphan(po2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic v; logic [15:0] d; } item_t;
    typedef struct packed {
        logic v0; logic [15:0] o0; logic v1; logic [15:0] o1; logic p; logic orph;
    } exp_t;

    // Model state: in-flight beats per instance (index k has latency k+1)
    item_t       line [2][$];
    logic        m_v [2];
    logic [15:0] m_o [2];
    logic        m_pend;
    logic        m_orph;
    logic [10:0] m_pfx;
    exp_t        expq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for the upcoming clock edge, from the current inputs
    task automatic model_edge();
        int          fld;
        int          w;
        int          r;
        logic [15:0] val;
        logic        acc;
        item_t       it;
        exp_t        e;
        if (rst) begin
            m_pend = 1'b0;
            m_orph = 1'b0;
            m_pfx  = '0;
            for (int k = 0; k < 2; k++) begin
                line[k].delete();
                for (int j = 0; j < k; j++) line[k].push_back(17'h0);
                m_v[k] = 1'b0;
                m_o[k] = 16'h0;
            end
        end else begin
            fld = sel_b ? int'(imm_b) : int'(imm_a);
            w   = sel_b ? 8 : 5;
            if (PFX_EN && m_pend) r = int'(m_pfx) * (1 << w) + fld;
            else if (!zext && fld >= (1 << (w - 1))) r = fld - (1 << w);
            else r = fld;
            val = r[15:0];
            acc = valid_in && !(PFX_EN && pfx_load) && !stall && !flush;
            if (flush) begin
                if (PFX_EN && m_pend) m_orph = 1'b1;
                else if (PFX_EN && err_clr) m_orph = 1'b0;
                m_pend = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    for (int j = 0; j < line[k].size(); j++) line[k][j].v = 1'b0;
                    m_v[k] = 1'b0;
                end
            end else if (!stall) begin
                if (PFX_EN && pfx_load) begin
                    m_pfx  = pfx_data;
                    m_pend = 1'b1;
                end else if (acc) begin
                    m_pend = 1'b0;
                end
                if (PFX_EN && err_clr) m_orph = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    line[k].push_back({acc, val});
                    it     = line[k].pop_front();
                    m_v[k] = it.v;
                    if (it.v) m_o[k] = it.d;
                end
            end
        end
        e = {m_v[0], m_o[0], m_v[1], m_o[1], m_pend, m_orph};
        expq.push_back(e);
    endtask

    // Drive one cycle of inputs, record the expectation, wait past the edge
    task automatic step(input logic v, input logic [4:0] a, input logic [7:0] b,
                        input logic sb, input logic z, input logic pl,
                        input logic [10:0] pd, input logic st, input logic fl,
                        input logic ec, input logic r);
        valid_in = v;  imm_a = a;  imm_b = b;  sel_b = sb;  zext = z;
        pfx_load = pl; pfx_data = pd; stall = st; flush = fl; err_clr = ec; rst = r;
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 5'h0, 8'h0, 0, 0, 0, 11'h0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every post-edge output against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() == 0) begin
                chk("queue_underflow", 32'd0, 32'd1);
            end else begin
                e = expq.pop_front();
                chk("p1_out_valid", 32'(ov1), 32'(e.v0));
                chk("p1_out",       32'(o1),  32'(e.o0));
                chk("p2_out_valid", 32'(ov2), 32'(e.v1));
                chk("p2_out",       32'(o2),  32'(e.o1));
                chk("p1_pfx_pending", 32'(pp1), 32'(e.p));
                chk("p2_pfx_pending", 32'(pp2), 32'(e.p));
                chk("p1_pfx_orphan",  32'(po1), 32'(e.orph));
                chk("p2_pfx_orphan",  32'(po2), 32'(e.orph));
            end
        end
    end

    // Stimulus: directed scenarios with literal spot checks, then random
    initial begin
        step(0, 5'h0, 8'h0, 0, 0, 0, 11'h0, 0, 0, 0, 1);
        step(0, 5'h0, 8'h0, 0, 0, 0, 11'h0, 0, 0, 0, 1);
        chk("reset_out", 32'(o1), 32'h0);
        chk("reset_out_valid", 32'(ov1), 32'h0);

        // Short field sign-extended; PIPE=2 trails by one cycle
        step(1, 5'b10101, 8'h0, 0, 0, 0, 11'h0, 0, 0, 0, 0);
        chk("sext_a_p1", 32'(o1), 32'hFFF5);
        chk("sext_a_p1_valid", 32'(ov1), 32'h1);
        chk("sext_a_p2_not_yet", 32'(ov2), 32'h0);
        idle();
        chk("sext_a_p2", 32'(o2), 32'hFFF5);
        chk("sext_a_p2_valid", 32'(ov2), 32'h1);
        chk("idle_p1_valid", 32'(ov1), 32'h0);
        chk("idle_p1_hold", 32'(o1), 32'hFFF5);

        // Long field zero- then sign-extended
        step(1, 5'h0, 8'hA5, 1, 1, 0, 11'h0, 0, 0, 0, 0);
        chk("zext_b", 32'(o1), 32'h00A5);
        step(1, 5'h0, 8'hA5, 1, 0, 0, 11'h0, 0, 0, 0, 0);
        chk("sext_b", 32'(o1), 32'hFFA5);
        idle();

`ifdef IMM_GEN_PREFIX_EN
        // Prefix concatenation
        step(0, 5'h0, 8'h0, 0, 0, 1, 11'h7FF, 0, 0, 0, 0);
        chk("pfx_pending_set", 32'(pp1), 32'h1);
        step(1, 5'b00011, 8'h0, 0, 0, 0, 11'h0, 0, 0, 0, 0);
        chk("pfx_concat", 32'(o1), 32'hFFE3);
        chk("pfx_pending_clr", 32'(pp1), 32'h0);
        // Flush orphans the pending prefix; next immediate is plain
        step(0, 5'h0, 8'h0, 0, 0, 1, 11'h123, 0, 0, 0, 0);
        step(0, 5'h0, 8'h0, 0, 0, 0, 11'h0, 0, 1, 0, 0);
        chk("flush_pending", 32'(pp1), 32'h0);
        chk("flush_orphan", 32'(po1), 32'h1);
        step(1, 5'b00101, 8'h0, 0, 0, 0, 11'h0, 0, 0, 0, 0);
        chk("post_flush_plain", 32'(o1), 32'h0005);
        step(0, 5'h0, 8'h0, 0, 0, 0, 11'h0, 0, 0, 1, 0);
        chk("err_clr", 32'(po1), 32'h0);
`endif

        // Stall freezes the output stage
        step(1, 5'h09, 8'h0, 0, 1, 0, 11'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 5'h0, 8'h0, 0, 0, 0, 11'h0, 1, 0, 0, 0);
            chk("stall_hold_out", 32'(o1), 32'h0009);
            chk("stall_hold_valid", 32'(ov1), 32'h1);
        end
        idle();

        // Reset mid-operation
        step(0, 5'h0, 8'h0, 0, 0, 1, 11'h2AA, 0, 0, 0, 0);
        step(1, 5'h1F, 8'h0, 0, 0, 0, 11'h0, 0, 0, 0, 0);
        step(1, 5'h1F, 8'h0, 0, 0, 0, 11'h0, 0, 0, 0, 1);
        chk("rst_out_p1", 32'(o1), 32'h0);
        chk("rst_out_p2", 32'(o2), 32'h0);
        chk("rst_valid_p2", 32'(ov2), 32'h0);
        chk("rst_pending", 32'(pp1), 32'h0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(99) < 60,
                 5'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom),
                 $urandom_range(99) < 15, 11'($urandom),
                 $urandom_range(99) < 15, $urandom_range(99) < 5,
                 $urandom_range(99) < 10, $urandom_range(999) < 5);
        end
        idle();
        chk("queue_drained", 32'(expq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen.md
IMM_GEN -- requirements
Module: imm_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 16, output word width.
REQ-002 SHALL have parameter IMM_A_W, default 5, short immediate field width.
REQ-003 SHALL have parameter IMM_B_W, default 8, long immediate field width.
REQ-004 SHALL have parameter PFX_W, default 11, prefix payload width.
REQ-005 SHALL have parameter PIPE, default 1, output register stages; legal values 1 or 2.
REQ-006 SHALL have one clock and one reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port valid_in  in  1  decode slot carries an immediate.
REQ-008 SHALL have port imm_a  in  IMM_A_W  short field.
REQ-009 SHALL have port imm_b  in  IMM_B_W  long field.
REQ-010 SHALL have port sel_b  in  1  1 selects imm_b, 0 selects imm_a.
REQ-011 SHALL have port zext  in  1  1 zero-extends, 0 sign-extends.
REQ-012 SHALL have port pfx_load  in  1  prefix instruction present.
REQ-013 SHALL have port pfx_data  in  PFX_W  prefix payload.
REQ-014 SHALL have port stall  in  1  hold all state.
REQ-015 SHALL have port flush  in  1  discard pipeline and pending prefix.
REQ-016 SHALL have port err_clr  in  1  clear sticky pfx_orphan.
REQ-017 SHALL have port out  out  DATA_W  extended immediate.
REQ-018 SHALL have port out_valid  out  1  out is meaningful.
REQ-019 SHALL have port pfx_pending  out  1  prefix latched, not yet consumed.
REQ-020 SHALL have port pfx_orphan  out  1  sticky: a pending prefix was flushed.

Function
REQ-021 Plain result: selected field sign- or zero-extended to DATA_W.
REQ-022 Prefixed result (pfx_pending=1): (pfx_reg << selected field width) | zero-extended field, truncated to DATA_W; zext ignored.
REQ-023 Accept on valid_in & ~pfx_load & ~stall & ~flush; consuming the prefix clears pfx_pending in the same edge.
REQ-024 pfx_load & ~stall & ~flush latches pfx_data, sets pfx_pending; valid_in that cycle is ignored.
REQ-025 pfx_load while pfx_pending overwrites the prefix; no error.
REQ-026 Latency = PIPE cycles from accept to out/out_valid; out_valid=0 for non-accepted cycles.
REQ-027 stall=1 freezes every register including outputs; flush overrides stall.
REQ-028 flush: all stages out_valid=0, pfx_pending=0; if pfx_pending was 1, set pfx_orphan.
REQ-029 err_clr clears pfx_orphan; simultaneous set (flush) wins over err_clr.
REQ-030 out holds last value when out_valid=0.

Reset
REQ-031 rst SHALL force out=0, out_valid=0, pfx_pending=0, pfx_orphan=0, prefix register=0, all stages cleared; rst overrides all inputs including mid-operation.

Configuration
REQ-032 Macro IMM_GEN_PREFIX_EN defined: prefix behaviour per REQ-022..REQ-029.
REQ-033 Macro undefined: prefix register absent, pfx_load ignored (valid_in accepted regardless), pfx_pending and pfx_orphan tied 0.

Structure
REQ-034 Package imm_pkg SHALL hold default widths and the PIPE legal range constants.
REQ-035 Sub-module imm_ext (combinational field select plus extend/concatenate) SHALL be instantiated once; pipeline and prefix state live in imm_gen.

Verification (DATA_W=16, defaults)
REQ-036 imm_a=5'b10101, sel_b=0, zext=0, valid_in -> out=16'hFFF5, out_valid one cycle later.
REQ-037 imm_b=8'hA5, sel_b=1, zext=1 -> out=16'h00A5; zext=0 -> 16'hFFA5.
REQ-038 pfx_load pfx_data=11'h7FF, then imm_a=5'b00011 -> out=16'hFFE3, pfx_pending 1 then 0.
REQ-039 Prefix pending, flush -> pfx_pending=0, pfx_orphan=1; next imm_a=5'b00101, zext=0 -> 16'h0005; err_clr -> pfx_orphan=0.
REQ-040 Accept then stall 3 cycles -> out/out_valid unchanged; PIPE=2 -> result two cycles after accept.
REQ-041 rst asserted with prefix pending and valid in flight -> all outputs 0 next cycle.
